crc32_stream_checker: RTL and testbench

Receive-side counterpart to the CRC-32 generator custom instruction. It consumes a 32-bit packet stream whose frames end in an appended little-endian CRC-32 FCS, and runs the same CRC-32 over payload plus FCS. It checks the result against the fixed residue and reports one status record per frame over a valid/ready handshake. It sits between the packet ingress logic and the Nios II, and flags corrupted frames without software CRC work.

---
 rtl/crc32_pkg.sv | 20 ++
 rtl/crc32_word_update.sv | 26 ++
 rtl/crc32_stream_checker.sv | 105 ++++++++++
 tb/tb_crc32_stream_checker.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc32_pkg.sv
// Shared CRC-32 (reflected 0x04C11DB7) constants, checker state encoding and beat helpers.
package crc32_pkg;

    localparam logic [31:0] POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;
    localparam logic [31:0] RESIDUE   = 32'hDEBB20E3;
    localparam int unsigned MIN_LEN   = 5;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        STATUS
    } state_t;

    // Valid bytes carried by a beat: all four unless this is the EOP beat.
    function automatic logic [2:0] byte_count(input logic eop, input logic [1:0] empty);
        return eop ? (3'd4 - {1'b0, empty}) : 3'd4;
    endfunction

endpackage

// File: rtl/crc32_word_update.sv
// Combinational CRC-32 update over up to four bytes, byte0 first, each byte LSB-first.
module crc32_word_update
    import crc32_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [31:0] data,
    input  logic [2:0]  nbytes,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < nbytes) begin
                c = c ^ {24'h0, data[8*b +: 8]};
                for (int k = 0; k < 8; k++) begin
                    c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
                end
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/crc32_stream_checker.sv
// Receive-side CRC-32 frame checker: runs CRC over payload+FCS and emits one status per frame.
module crc32_stream_checker
    import crc32_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [1:0]       in_empty,
    output logic             stat_valid,
    input  logic             stat_ready,
    output logic             stat_ok,
    output logic             stat_runt,
    output logic [LEN_W-1:0] stat_len,
    output logic [31:0]      stat_residue,
    output logic [15:0]      drop_count,
    output logic [15:0]      abort_count
);

    state_t           state;
    logic [31:0]      crc_q;
    logic [LEN_W-1:0] len_q;

    logic             accept;
    logic [2:0]       nbytes;
    logic [31:0]      crc_base;
    logic [31:0]      crc_next;
    logic [LEN_W:0]   len_sum;
    logic [LEN_W-1:0] len_next;
    logic             runt_next;

    assign accept   = in_valid & in_ready;
    assign nbytes   = byte_count(in_eop, in_empty);
    assign crc_base = in_sop ? CRC_INIT : crc_q;

    // SOP restarts the length; otherwise accumulate and saturate at all-ones.
    assign len_sum   = (in_sop ? '0 : {1'b0, len_q}) + (LEN_W+1)'(nbytes);
    assign len_next  = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
    assign runt_next = len_next < LEN_W'(MIN_LEN);

    crc32_word_update u_word_update (
        .crc_in  (crc_base),
        .data    (in_data),
        .nbytes  (nbytes),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            crc_q        <= CRC_INIT;
            len_q        <= '0;
            in_ready     <= 1'b1;
            stat_valid   <= 1'b0;
            stat_ok      <= 1'b0;
            stat_runt    <= 1'b0;
            stat_len     <= '0;
            stat_residue <= '0;
            drop_count   <= '0;
            abort_count  <= '0;
        end else begin
            case (state)
                IDLE, FRAME: begin
                    if (accept) begin
                        if (in_sop || state == FRAME) begin
                            if (in_sop && state == FRAME) begin
                                abort_count <= abort_count + 16'd1;
                            end
                            crc_q <= crc_next;
                            len_q <= len_next;
                            if (in_eop) begin
                                state        <= STATUS;
                                in_ready     <= 1'b0;
                                stat_valid   <= 1'b1;
                                stat_len     <= len_next;
                                stat_residue <= crc_next;
                                stat_runt    <= runt_next;
                                stat_ok      <= (crc_next == RESIDUE) && !runt_next;
                            end else begin
                                state <= FRAME;
                            end
                        end else begin
                            drop_count <= drop_count + 16'd1;
                        end
                    end
                end
                STATUS: begin
                    if (stat_ready) begin
                        state      <= IDLE;
                        stat_valid <= 1'b0;
                        in_ready   <= 1'b1;
                        crc_q      <= CRC_INIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc32_stream_checker.sv
// Self-checking bench for crc32_stream_checker against a bit-serial byte-queue CRC model.
module tb_crc32_stream_checker;

    localparam int unsigned LEN_W = 16;

    typedef logic [7:0] u8_t;
    typedef u8_t q_t[$];

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic             in_sop;
    logic             in_eop;
    logic [1:0]       in_empty;
    logic             stat_valid;
    logic             stat_ready;
    logic             stat_ok;
    logic             stat_runt;
    logic [LEN_W-1:0] stat_len;
    logic [31:0]      stat_residue;
    logic [15:0]      drop_count;
    logic [15:0]      abort_count;

    int tests  = 0;
    int fails  = 0;
    int hs_cnt = 0;

    crc32_stream_checker #(.LEN_W(LEN_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sop       (in_sop),
        .in_eop       (in_eop),
        .in_empty     (in_empty),
        .stat_valid   (stat_valid),
        .stat_ready   (stat_ready),
        .stat_ok      (stat_ok),
        .stat_runt    (stat_runt),
        .stat_len     (stat_len),
        .stat_residue (stat_residue),
        .drop_count   (drop_count),
        .abort_count  (abort_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (stat_valid && stat_ready) hs_cnt <= hs_cnt + 1;
    end

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: observed no finish, expected finish within 200000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Classic bit-at-a-time reflected CRC over the whole byte sequence, no final XOR.
    function automatic logic [31:0] ref_raw(input q_t q);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    function automatic q_t with_fcs(input q_t p);
        logic [31:0] fcs;
        fcs = ~ref_raw(p);
        for (int k = 0; k < 4; k++) p.push_back(fcs[8*k +: 8]);
        return p;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, ".in_ready"},     32'(in_ready),     32'd1);
        check({tag, ".stat_valid"},   32'(stat_valid),   32'd0);
        check({tag, ".stat_ok"},      32'(stat_ok),      32'd0);
        check({tag, ".stat_runt"},    32'(stat_runt),    32'd0);
        check({tag, ".stat_len"},     32'(stat_len),     32'd0);
        check({tag, ".stat_residue"}, stat_residue,      32'd0);
        check({tag, ".drop_count"},   32'(drop_count),   32'd0);
        check({tag, ".abort_count"},  32'(abort_count),  32'd0);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop,
                             input logic [1:0] empty);
        int n;
        n        = 0;
        in_data  = d;
        in_sop   = sop;
        in_eop   = eop;
        in_empty = empty;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n >= 100) begin
                check("in_ready_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic send_bytes(input q_t q, input int gaps);
        int sz;
        sz = q.size();
        for (int i = 0; i < sz; i += 4) begin
            logic [31:0] w;
            logic        last;
            logic [1:0]  emp;
            w = $urandom;
            for (int j = 0; j < 4; j++) begin
                if (i + j < sz) w[8*j +: 8] = q[i+j];
            end
            last = (i + 4 >= sz);
            emp  = last ? 2'(4 - (sz - i)) : 2'($urandom);
            if (gaps > 0) begin
                repeat ($urandom_range(0, gaps)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(w, i == 0, last, emp);
        end
    endtask

    task automatic expect_status(input string tag, input logic ok, input logic runt,
                                 input logic [31:0] len, input logic [31:0] res);
        @(negedge clk);
        check({tag, ".valid"},   32'(stat_valid), 32'd1);
        check({tag, ".ok"},      32'(stat_ok),    32'(ok));
        check({tag, ".runt"},    32'(stat_runt),  32'(runt));
        check({tag, ".len"},     32'(stat_len),   len);
        check({tag, ".residue"}, stat_residue,    res);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string tag, input q_t q, input int gaps);
        logic [31:0] res;
        logic [31:0] len;
        logic        runt;
        logic        ok;
        int          h0;
        res  = ref_raw(q);
        len  = (q.size() > 65535) ? 32'd65535 : 32'(q.size());
        runt = q.size() < 5;
        ok   = (res == 32'hDEBB20E3) && !runt;
        h0   = hs_cnt;
        send_bytes(q, gaps);
        expect_status(tag, ok, runt, len, res);
        check({tag, ".one_status"}, 32'(hs_cnt - h0), 32'd1);
    endtask

    initial begin : main
        q_t          known_p;
        q_t          known;
        q_t          q;
        string       s;
        int          h0;
        logic [31:0] exp_res;

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_sop     = 1'b0;
        in_eop     = 1'b0;
        in_empty   = 2'd0;
        in_data    = 32'd0;
        stat_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        s = "123456789";
        for (int i = 0; i < 9; i++) known_p.push_back(u8_t'(s[i]));
        known = with_fcs(known_p);

        // Literal beats of "123456789" + FCS
        h0 = hs_cnt;
        send_beat(32'h34333231, 1'b1, 1'b0, 2'd0);
        send_beat(32'h38373635, 1'b0, 1'b0, 2'd0);
        send_beat(32'hF4392639, 1'b0, 1'b0, 2'd0);
        send_beat(32'h000000CB, 1'b0, 1'b1, 2'd3);
        expect_status("known", 1'b1, 1'b0, 32'd13, 32'hDEBB20E3);
        check("known.one_status", 32'(hs_cnt - h0), 32'd1);

        q    = known;
        q[4] = q[4] ^ 8'h01;
        run_frame("corrupt", q, 0);

        q = {8'h00, 8'h00, 8'h00, 8'h00};
        run_frame("runt", q, 0);

        // Status held under backpressure
        stat_ready = 1'b0;
        q = {};
        for (int i = 0; i < 10; i++) q.push_back(u8_t'($urandom));
        q       = with_fcs(q);
        exp_res = ref_raw(q);
        h0      = hs_cnt;
        send_bytes(q, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp.valid",    32'(stat_valid), 32'd1);
            check("bp.in_ready", 32'(in_ready),   32'd0);
            check("bp.ok",       32'(stat_ok),    32'd1);
            check("bp.len",      32'(stat_len),   32'd14);
            check("bp.residue",  stat_residue,    exp_res);
        end
        stat_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp.hs",          32'(hs_cnt - h0), 32'd1);
        check("bp.valid_after", 32'(stat_valid),  32'd0);
        check("bp.ready_after", 32'(in_ready),    32'd1);
        q = {};
        for (int i = 0; i < 7; i++) q.push_back(u8_t'($urandom));
        run_frame("bp.next", with_fcs(q), 0);

        // Stray beats outside a frame
        h0 = hs_cnt;
        send_beat($urandom, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        check("stray.drop1", 32'(drop_count), 32'd1);
        check("stray.valid", 32'(stat_valid), 32'd0);
        @(posedge clk);
        #1;
        send_beat($urandom, 1'b0, 1'b1, 2'd1);
        @(negedge clk);
        check("stray.drop2",   32'(drop_count), 32'd2);
        check("stray.no_stat", 32'(hs_cnt - h0), 32'd0);
        @(posedge clk);
        #1;

        // Mid-frame SOP aborts the partial frame
        send_beat($urandom, 1'b1, 1'b0, 2'd0);
        send_beat($urandom, 1'b0, 1'b0, 2'd0);
        run_frame("abort", known, 0);
        check("abort.count", 32'(abort_count), 32'd1);
        check("abort.drop",  32'(drop_count),  32'd2);

        // Reset in the middle of a frame
        h0 = hs_cnt;
        send_beat(32'h34333231, 1'b1, 1'b0, 2'd0);
        send_beat(32'h38373635, 1'b0, 1'b0, 2'd0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("rst_mid");
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_mid.no_stat", 32'(hs_cnt - h0), 32'd0);
        run_frame("rst_mid.resend", known, 0);

        // Reset while a status is pending
        stat_ready = 1'b0;
        h0 = hs_cnt;
        send_bytes(known, 0);
        @(negedge clk);
        check("rst_stat.valid", 32'(stat_valid), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_values("rst_stat");
        @(posedge clk);
        #1;
        reset      = 1'b0;
        stat_ready = 1'b1;
        check("rst_stat.no_stat", 32'(hs_cnt - h0), 32'd0);

        // Random frames, some corrupted, some runts, with idle gaps
        for (int f = 0; f < 25; f++) begin
            q = {};
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 4)) q.push_back(u8_t'($urandom));
            end else begin
                repeat ($urandom_range(1, 40)) q.push_back(u8_t'($urandom));
                q = with_fcs(q);
                if ($urandom_range(0, 1) == 1) begin
                    int idx;
                    idx    = $urandom_range(0, q.size() - 1);
                    q[idx] = q[idx] ^ (8'h01 << $urandom_range(0, 7));
                end
            end
            run_frame("random", q, 2);
        end

        // Length saturates while the CRC verdict still holds
        q = {};
        repeat (65540) q.push_back(u8_t'($urandom));
        run_frame("saturate", with_fcs(q), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
